// File: rtl/string_op_seq.sv
`default_nettype none
// ============================================================================
// Module      : string_op_seq
// Description : Execute-stage sequencer for MOVS/CMPS/STOS with REP prefixes.
// Revision    : 1.0 - initial release
// ============================================================================
module string_op_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [1:0]        rep,
    input  logic [1:0]        size,
    input  logic              df,
    input  logic [ADDR_W-1:0] ecx_in,
    input  logic [ADDR_W-1:0] esi_in,
    input  logic [ADDR_W-1:0] edi_in,
    input  logic [DATA_W-1:0] eax_in,
    input  logic              flush,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic [DATA_W-1:0] mem_out_latched,
    output logic [DATA_W-1:0] mem_out,
    input  logic              cmps_zf,
    output logic              ld_cmps_flags,
    output logic [ADDR_W-1:0] ecx_out,
    output logic [ADDR_W-1:0] esi_out,
    output logic [ADDR_W-1:0] edi_out,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] C_OP_MOVS = 2'b00;
    localparam logic [1:0] C_OP_CMPS = 2'b01;
    localparam logic [1:0] C_OP_STOS = 2'b10;
    localparam logic [1:0] C_REP_E   = 2'b01;
    localparam logic [1:0] C_REP_NE  = 2'b10;

    typedef enum logic [2:0] {
        C_IDLE   = 3'd0,
        C_CHECK  = 3'd1,
        C_RD_SRC = 3'd2,
        C_RD_DST = 3'd3,
        C_WR_DST = 3'd4,
        C_CMP    = 3'd5,
        C_UPDATE = 3'd6,
        C_FIN    = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_op;
    logic [1:0]          r_rep;
    logic [1:0]          r_size;
    logic                r_df;
    logic [ADDR_W-1:0]   r_ecx;
    logic [ADDR_W-1:0]   r_esi;
    logic [ADDR_W-1:0]   r_edi;
    logic [DATA_W-1:0]   r_buf;
    logic [DATA_W-1:0]   r_mem_lat;
    logic [DATA_W-1:0]   r_mem_out;
    logic                r_zf;
    logic                r_gap;

    logic [ADDR_W-1:0]   w_step;
    logic [ADDR_W-1:0]   w_esi_nxt;
    logic [ADDR_W-1:0]   w_edi_nxt;
    logic [ADDR_W-1:0]   w_ecx_dec;
    logic [DATA_W-1:0]   w_mask;
    logic                w_rep_on;
    logic                w_is_cmps;
    logic                w_stop;
    logic                w_rd_fire;
    logic                w_wr_fire;

    always_comb begin
        w_step = ADDR_W'(4);
        w_mask = '1;
        case (r_size)
            2'b00: begin
                w_step = ADDR_W'(1);
                w_mask = DATA_W'(32'h0000_00FF);
            end
            2'b01: begin
                w_step = ADDR_W'(2);
                w_mask = DATA_W'(32'h0000_FFFF);
            end
            default: ;
        endcase
    end

    assign w_esi_nxt = r_df ? (r_esi - w_step) : (r_esi + w_step);
    assign w_edi_nxt = r_df ? (r_edi - w_step) : (r_edi + w_step);
    assign w_ecx_dec = r_ecx - ADDR_W'(1);
    assign w_rep_on  = (r_rep != 2'b00);
    assign w_is_cmps = (r_op == C_OP_CMPS);
    assign w_stop    = !w_rep_on || (w_ecx_dec == '0) ||
                       (w_is_cmps && r_rep == C_REP_E  && !r_zf) ||
                       (w_is_cmps && r_rep == C_REP_NE &&  r_zf);

    // A request is withheld for one cycle after any accepted ack.
    assign rd_req    = (r_state == C_RD_SRC || r_state == C_RD_DST) && !r_gap;
    assign wr_req    = (r_state == C_WR_DST) && !r_gap;
    assign w_rd_fire = rd_req && rd_ack;
    assign w_wr_fire = wr_req && wr_ack;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE:   if (start) w_state_nxt = C_CHECK;
            C_CHECK: begin
                if (w_rep_on && r_ecx == '0) begin
                    w_state_nxt = C_FIN;
                end else begin
                    case (r_op)
                        C_OP_MOVS, C_OP_CMPS: w_state_nxt = C_RD_SRC;
                        C_OP_STOS:            w_state_nxt = C_WR_DST;
                        default:              w_state_nxt = C_FIN;
                    endcase
                end
            end
            C_RD_SRC: if (w_rd_fire) w_state_nxt = w_is_cmps ? C_RD_DST : C_WR_DST;
            C_RD_DST: if (w_rd_fire) w_state_nxt = C_CMP;
            C_CMP:    w_state_nxt = C_UPDATE;
            C_WR_DST: if (w_wr_fire) w_state_nxt = C_UPDATE;
            C_UPDATE: w_state_nxt = w_stop ? C_FIN : C_CHECK;
            C_FIN:    w_state_nxt = C_IDLE;
            default:  w_state_nxt = C_IDLE;
        endcase
        if (flush) w_state_nxt = C_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= C_IDLE;
            r_op      <= '0;
            r_rep     <= '0;
            r_size    <= '0;
            r_df      <= 1'b0;
            r_ecx     <= '0;
            r_esi     <= '0;
            r_edi     <= '0;
            r_buf     <= '0;
            r_mem_lat <= '0;
            r_mem_out <= '0;
            r_zf      <= 1'b0;
            r_gap     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= (w_rd_fire || w_wr_fire) && !flush;
            // Flush discards any ack and any pending register commit.
            if (!flush) begin
                case (r_state)
                    C_IDLE: if (start) begin
                        r_op   <= op;
                        r_rep  <= (rep == 2'b11) ? 2'b00 : rep;
                        r_size <= size;
                        r_df   <= df;
                        r_ecx  <= ecx_in;
                        r_esi  <= esi_in;
                        r_edi  <= edi_in;
                    end
                    C_RD_SRC: if (w_rd_fire) begin
                        if (w_is_cmps) r_mem_lat <= rd_data & w_mask;
                        else           r_buf     <= rd_data;
                    end
                    C_RD_DST: if (w_rd_fire) r_mem_out <= rd_data & w_mask;
                    C_CMP:    r_zf <= cmps_zf;
                    C_UPDATE: begin
                        if (r_op != C_OP_STOS) r_esi <= w_esi_nxt;
                        r_edi <= w_edi_nxt;
                        if (w_rep_on) r_ecx <= w_ecx_dec;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_addr         = (r_state == C_RD_DST) ? r_edi : r_esi;
    assign wr_addr         = r_edi;
    assign wr_data         = (r_op == C_OP_STOS) ? eax_in : r_buf;
    assign mem_out_latched = r_mem_lat;
    assign mem_out         = r_mem_out;
    assign ld_cmps_flags   = (r_state == C_CMP) && !flush;
    assign ecx_out         = r_ecx;
    assign esi_out         = r_esi;
    assign edi_out         = r_edi;
    assign busy            = (r_state != C_IDLE);
    assign done            = (r_state == C_FIN) && !flush;

endmodule
`default_nettype wire

// File: tb/tb_string_op_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_string_op_seq
// Description : Directed self-checking bench for string_op_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_string_op_seq;

    logic        clk = 1'b0;
    logic        rst, start, df, flush;
    logic [1:0]  op, rep, size;
    logic [31:0] ecx_in, esi_in, edi_in, eax_in;
    logic        rd_req, rd_ack, wr_req, wr_ack, cmps_zf, ld_cmps_flags, busy, done;
    logic [31:0] rd_addr, rd_data, wr_addr, wr_data, mem_out_latched, mem_out;
    logic [31:0] ecx_out, esi_out, edi_out;

    string_op_seq #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rep(rep), .size(size),
        .df(df), .ecx_in(ecx_in), .esi_in(esi_in), .edi_in(edi_in),
        .eax_in(eax_in), .flush(flush), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .mem_out_latched(mem_out_latched),
        .mem_out(mem_out), .cmps_zf(cmps_zf), .ld_cmps_flags(ld_cmps_flags),
        .ecx_out(ecx_out), .esi_out(esi_out), .edi_out(edi_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          n_rd = 0, n_wr = 0, n_ld = 0, n_done = 0;
    int          b_rd, b_wr, b_ld, b_done;
    logic [31:0] wa [0:63];
    logic [31:0] wd [0:63];
    logic        hold_ack = 1'b0;
    logic [7:0]  zf_seq = 8'h00;
    int          ld_base = 0;

    // Memory model: every location reads as its address plus 0x1134.
    always @(negedge clk) begin
        rd_ack  = rd_req && !hold_ack;
        rd_data = rd_addr + 32'h1134;
        wr_ack  = wr_req && !hold_ack;
        cmps_zf = zf_seq[3'(n_ld - ld_base)];
    end

    always @(posedge clk) begin
        if (done)          n_done <= n_done + 1;
        if (ld_cmps_flags) n_ld   <= n_ld + 1;
        if (rd_req && rd_ack) n_rd <= n_rd + 1;
        if (wr_req && wr_ack) begin
            wa[6'(n_wr)] <= wr_addr;
            wd[6'(n_wr)] <= wr_data;
            n_wr         <= n_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_rd = n_rd; b_wr = n_wr; b_ld = n_ld; b_done = n_done; ld_base = n_ld;
    endtask

    task automatic issue(input logic [1:0] o, input logic [1:0] r, input logic [1:0] s,
                         input logic d, input logic [31:0] c, input logic [31:0] si,
                         input logic [31:0] di, input logic [31:0] ax);
        @(negedge clk);
        op = o; rep = r; size = s; df = d;
        ecx_in = c; esi_in = si; edi_in = di; eax_in = ax;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300 && n_done == b_done; i++) @(negedge clk);
        @(negedge clk);
        chk(tag, n_done - b_done, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rep = '0; size = '0;
        df = 1'b0; ecx_in = '0; esi_in = '0; edi_in = '0; eax_in = '0;
        rd_ack = 1'b0; wr_ack = 1'b0; rd_data = '0; cmps_zf = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ctrl", 32'({busy, done, rd_req, wr_req, ld_cmps_flags}), 0);
        chk("rst_data", rd_addr | wr_addr | wr_data | mem_out | mem_out_latched |
                        ecx_out | esi_out | edi_out, 0);

        // 1: single MOVS word
        snap();
        issue(2'b00, 2'b00, 2'b01, 1'b0, 32'h7, 32'h100, 32'h200, 32'h0);
        wait_done("movs_done");
        chk("movs_nwr", n_wr - b_wr, 1);
        chk("movs_nrd", n_rd - b_rd, 1);
        chk("movs_waddr", wa[6'(b_wr)], 32'h200);
        chk("movs_wdata", wd[6'(b_wr)], 32'h1234);
        chk("movs_esi", esi_out, 32'h102);
        chk("movs_edi", edi_out, 32'h202);
        chk("movs_ecx", ecx_out, 32'h7);

        // 2: REP STOS byte, decrementing
        snap();
        issue(2'b10, 2'b01, 2'b00, 1'b1, 32'h3, 32'h55, 32'h10, 32'hAB);
        wait_done("stos_done");
        chk("stos_nwr", n_wr - b_wr, 3);
        chk("stos_wa0", wa[6'(b_wr)], 32'h10);
        chk("stos_wa1", wa[6'(b_wr + 1)], 32'h0F);
        chk("stos_wa2", wa[6'(b_wr + 2)], 32'h0E);
        chk("stos_wd2", wd[6'(b_wr + 2)], 32'hAB);
        chk("stos_ecx", ecx_out, 32'h0);
        chk("stos_edi", edi_out, 32'h0D);
        chk("stos_esi", esi_out, 32'h55);

        // 3: REP MOVS with ECX=0
        snap();
        issue(2'b00, 2'b01, 2'b10, 1'b0, 32'h0, 32'h300, 32'h400, 32'h0);
        chk("rep0_done_early", 32'(done), 0);
        @(negedge clk);
        chk("rep0_done_t2", 32'(done), 1);
        repeat (2) @(negedge clk);
        chk("rep0_nmem", (n_rd - b_rd) + (n_wr - b_wr), 0);
        chk("rep0_ndone", n_done - b_done, 1);
        chk("rep0_regs", ecx_out ^ (esi_out ^ 32'h300) ^ (edi_out ^ 32'h400), 0);

        // 4: REPE CMPS dword, mismatch on the second compare
        snap();
        zf_seq = 8'b0000_0001;
        issue(2'b01, 2'b01, 2'b10, 1'b0, 32'h5, 32'h1000, 32'h2000, 32'h0);
        wait_done("repe_done");
        chk("repe_nld", n_ld - b_ld, 2);
        chk("repe_ecx", ecx_out, 32'h3);
        chk("repe_esi", esi_out, 32'h1008);
        chk("repe_edi", edi_out, 32'h2008);
        chk("repe_lat", mem_out_latched, 32'h2138);
        chk("repe_out", mem_out, 32'h3138);
        chk("repe_nwr", n_wr - b_wr, 0);

        // 5a: REPNE CMPS byte, match on first compare
        snap();
        zf_seq = 8'b0000_0001;
        issue(2'b01, 2'b10, 2'b00, 1'b0, 32'h4, 32'h500, 32'h6F1, 32'h0);
        wait_done("repne1_done");
        chk("repne1_nld", n_ld - b_ld, 1);
        chk("repne1_ecx", ecx_out, 32'h3);
        chk("repne1_lat", mem_out_latched, 32'h34);
        chk("repne1_out", mem_out, 32'h25);
        chk("repne1_edi", edi_out, 32'h6F2);

        // 5b: REPNE CMPS word df=1, never matches
        snap();
        zf_seq = 8'h00;
        issue(2'b01, 2'b10, 2'b01, 1'b1, 32'h2, 32'h800, 32'h900, 32'h0);
        wait_done("repne2_done");
        chk("repne2_nld", n_ld - b_ld, 2);
        chk("repne2_ecx", ecx_out, 32'h0);
        chk("repne2_esi", esi_out, 32'h7FC);
        chk("repne2_edi", edi_out, 32'h8FC);

        // 6a: flush while a read is outstanding
        snap();
        hold_ack = 1'b1;
        issue(2'b00, 2'b00, 2'b01, 1'b0, 32'h9, 32'h40, 32'h80, 32'h0);
        repeat (3) @(negedge clk);
        chk("fl_rdreq", 32'(rd_req), 1);
        chk("fl_rdaddr", rd_addr, 32'h40);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_idle", 32'({busy, rd_req, wr_req}), 0);
        hold_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("fl_nodone", n_done - b_done, 0);
        chk("fl_regs", 32'({ecx_out == 32'h9, esi_out == 32'h40, edi_out == 32'h80}), 32'h7);

        // 6b: reset mid REP STOS
        snap();
        issue(2'b10, 2'b01, 2'b00, 1'b0, 32'd10, 32'h0, 32'h20, 32'h11);
        for (int i = 0; i < 100 && (n_wr - b_wr) < 2; i++) @(negedge clk);
        chk("rst_mid_progress", 32'((n_wr - b_wr) >= 2), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_idle", 32'({busy, rd_req, wr_req, done}), 0);
        repeat (3) @(negedge clk);
        chk("rst_mid_nodone", n_done - b_done, 0);
        chk("rst_mid_ecx", ecx_out, 32'h0);

        // 6c: EDI wrap below zero
        snap();
        issue(2'b10, 2'b00, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0, 32'h5A);
        wait_done("wrap_done");
        chk("wrap_waddr", wa[6'(b_wr)], 32'h0);
        chk("wrap_wdata", wd[6'(b_wr)], 32'h5A);
        chk("wrap_edi", edi_out, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/string_op_seq.md
Name: string_op_seq

Overview:
- Execute-stage sequencer for x86 string instructions (MOVS, CMPS, STOS), with and without REP/REPE/REPNE prefixes.
- Drives memory read/write handshakes and holds the latched first operand for the CMPS compare in alu1.
- Consumes the ZF returned by alu1's cmps flags.
- Updates ECX/ESI/EDI per iteration and stalls the pipeline until the instruction retires.

Parameters:
DATA_W, 32, memory data width
ADDR_W, 32, address / index register width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle issue pulse; sampled only in IDLE
op  input  2  00 MOVS, 01 CMPS, 10 STOS, 11 reserved (treated as NOP)
rep  input  2  00 none, 01 REP/REPE, 10 REPNE, 11 = 00
size  input  2  00 byte, 01 word, 10 dword (11 = dword)
df  input  1  direction flag
ecx_in  input  ADDR_W  initial count
esi_in  input  ADDR_W  initial source index
edi_in  input  ADDR_W  initial destination index
eax_in  input  DATA_W  STOS store data
flush  input  1  synchronous abort
rd_req  output  1  memory read request
rd_addr  output  ADDR_W  read address
rd_ack  input  1  read complete; rd_data valid this cycle
rd_data  input  DATA_W  read data
wr_req  output  1  memory write request
wr_addr  output  ADDR_W  write address
wr_data  output  DATA_W  write data
wr_ack  input  1  write complete
mem_out_latched  output  DATA_W  first CMPS operand (from [ESI])
mem_out  output  DATA_W  second CMPS operand (from [EDI])
cmps_zf  input  1  ZF from alu1 cmps flags, valid the cycle after mem_out updates
ld_cmps_flags  output  1  one-cycle pulse: commit cmps flags
ecx_out, esi_out, edi_out  output  ADDR_W  live register values
busy  output  1  high in every state except IDLE
done  output  1  one-cycle retire pulse

Behaviour:
- Reset: state IDLE; all outputs 0 (busy, done, rd_req, wr_req, ld_cmps_flags, addresses, data, registers).
- Step = 1/2/4 by size; add when df=0, subtract when df=1; ADDR_W modular wrap (0x0 - 1 = 0xFFFF_FFFF).
- States: IDLE, CHECK, RD_SRC, RD_DST, WR_DST, CMP, UPDATE, FIN.
- IDLE: on start, latch op/rep/size/df and the three registers -> CHECK.
- CHECK:
  - rep!=0 and ECX==0 -> FIN; no memory access, no flag load.
  - MOVS/CMPS -> RD_SRC.
  - STOS -> WR_DST.
  - reserved op -> FIN.
- RD_SRC: rd_req=1, rd_addr=ESI, held stable until rd_ack.
  - On ack, capture rd_data.
  - CMPS: capture into mem_out_latched -> RD_DST.
  - MOVS: capture into the write buffer -> WR_DST.
- RD_DST: rd_addr=EDI; on ack mem_out<=rd_data -> CMP.
- CMP: one cycle; ld_cmps_flags=1; sample cmps_zf -> UPDATE.
- WR_DST: wr_req=1, wr_addr=EDI, wr_data = buffer (MOVS) or eax_in (STOS), held until wr_ack -> UPDATE.
- Req deassert: rd_req/wr_req drop the cycle after ack; no back-to-back reuse of the same request.
- UPDATE:
  - ESI += step (MOVS/CMPS only); EDI += step.
  - If rep!=0, ECX -= 1.
  - Go to FIN when any of: rep==0; new ECX==0; CMPS with rep=01 and zf=0; CMPS with rep=10 and zf=1.
  - Otherwise -> CHECK.
- FIN: done=1 for one cycle -> IDLE.
- Byte/word data: only low bits are meaningful; upper bits of mem_out/mem_out_latched are zero-extended.
- flush: in any state, next cycle is IDLE.
  - rd_req/wr_req deassert; no done, no ld_cmps_flags.
  - ecx/esi/edi_out keep their last committed values.
  - A flush coincident with an ack discards that ack.
- start while busy is ignored. rst has priority over flush; flush has priority over start.

Test Plan:
1. MOVS word, rep=00, ESI=0x100, EDI=0x200, df=0, read returns 0x1234 -> one write of 0x1234 to 0x200; ESI=0x102, EDI=0x202, ECX unchanged; done once.
2. REP STOS byte, ECX=3, EDI=0x10, df=1 -> writes to 0x10, 0x0F, 0x0E; ECX=0, EDI=0x0D; done after third wr_ack.
3. REP MOVS with ECX=0 -> no rd_req/wr_req; done two cycles after start; registers unchanged.
4. REPE CMPS dword, ECX=5; the second compare returns cmps_zf=0 -> exactly 2 ld_cmps_flags pulses; ECX=3; ESI/EDI advanced by 8.
5. REPNE CMPS, ECX=4, zf=1 on the first compare -> stops after one iteration with ECX=3; REPNE, ECX=2, zf=0 twice -> ECX=0.
6. Assert flush while rd_req waits on ack; separately, pulse rst mid REP STOS -> IDLE next cycle; no done; reqs low. Also check EDI=0x0 with df=1, byte -> EDI wraps to 0xFFFFFFFF.
